// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch stalls, E flush,
// and a data-memory handshake FSM that freezes F/D/E/M during multi-cycle accesses.
module hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       writeregE,
  input  logic [4:0]       writeregM,
  input  logic [4:0]       writeregW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memtoregM,
  input  logic             branchD,
  input  logic             memreqM,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             forwardaD,
  output logic             forwardbD,
  output logic [1:0]       forwardaE,
  output logic [1:0]       forwardbE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushW,
  output logic [CNT_W-1:0] stall_count,
  output logic             mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } memState_e;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT - 1);

  memState_e        state_q;
  logic             memReq_q;
  logic [15:0]      waitCnt_q;
  logic [CNT_W-1:0] stallCnt_q;
  logic             memErr_q;

  logic lwStall;
  logic branchStall;
  logic memStall;
  logic brHitE;
  logic brHitM;

  // M has the newer value, so it wins over W when both match.
  always_comb begin
    forwardaE = 2'b00;
    if (rsE != 5'd0 && regwriteM && rsE == writeregM)      forwardaE = 2'b10;
    else if (rsE != 5'd0 && regwriteW && rsE == writeregW) forwardaE = 2'b01;
    forwardbE = 2'b00;
    if (rtE != 5'd0 && regwriteM && rtE == writeregM)      forwardbE = 2'b10;
    else if (rtE != 5'd0 && regwriteW && rtE == writeregW) forwardbE = 2'b01;
  end

  assign forwardaD = (rsD != 5'd0) && regwriteM && (rsD == writeregM);
  assign forwardbD = (rtD != 5'd0) && regwriteM && (rtD == writeregM);

  assign lwStall = memtoregE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));

  assign brHitE = regwriteE && (writeregE != 5'd0) &&
                  ((writeregE == rsD) || (writeregE == rtD));
  assign brHitM = memtoregM && (writeregM != 5'd0) &&
                  ((writeregM == rsD) || (writeregM == rtD));
  assign branchStall = branchD && (brHitE || brHitM);

  // The memory stall starts in the request cycle itself so M holds before WAIT.
  assign memStall = !reset && ((state_q == IDLE && memreqM) || (state_q == WAIT));

  assign stallF = lwStall || branchStall || memStall;
  assign stallD = stallF;
  assign stallE = memStall;
  assign stallM = memStall;
  assign flushE = (lwStall || branchStall) && !memStall;
  assign flushW = memStall;

  assign mem_req     = memReq_q;
  assign stall_count = stallCnt_q;
  assign mem_err     = memErr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      waitCnt_q  <= 16'd0;
      stallCnt_q <= '0;
      memErr_q   <= 1'b0;
    end else begin
      if (stallF && stallCnt_q != '1) stallCnt_q <= stallCnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (memreqM) begin
            state_q   <= WAIT;
            memReq_q  <= 1'b1;
            waitCnt_q <= 16'd0;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state_q   <= DONE;
            memReq_q  <= 1'b0;
            waitCnt_q <= 16'd0;
          end else begin
            if (waitCnt_q != 16'hFFFF) waitCnt_q <= waitCnt_q + 16'd1;
            if (waitCnt_q >= TIMEOUT_LIM) memErr_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          memReq_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
